// File: rtl/codec_config_seq_if.sv
// Host register-write handshake and 2-wire serial bus pins of the codec configuration sequencer.
interface codec_config_seq_if;
  logic        cfg_wr_valid;
  logic [15:0] cfg_wr_data;
  logic        cfg_wr_ready;
  logic        i2c_sclk;
  logic        i2c_sdat_oe;
  logic        i2c_sdat_in;

  modport slave (
    input  cfg_wr_valid, cfg_wr_data, i2c_sdat_in,
    output cfg_wr_ready, i2c_sclk, i2c_sdat_oe
  );

  modport master (
    output cfg_wr_valid, cfg_wr_data, i2c_sdat_in,
    input  cfg_wr_ready, i2c_sclk, i2c_sdat_oe
  );
endinterface

// File: rtl/codec_config_seq.sv
// Writes the fixed codec init table over a write-only 2-wire bus, then serves host register writes.
// Optional feature: define CODEC_CFG_RETRY_EN to re-send a NACKed word up to 3 times.
module codec_config_seq #(
  parameter int       CLK_DIV  = 125,
  parameter bit [6:0] DEV_ADDR = 7'h1A
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  codec_config_seq_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               audio_en
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_IDX = 4'd10;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP, READY, ERR} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [1:0]       q;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [3:0]       idx;
  logic             init_run;
  logic             nack_seen;
  logic [15:0]      word;
  logic [23:0]      shreg;
  logic [23:0]      frame;
  logic             q_end;
  logic             slot_end;
  logic             retry_ok;

  assign frame    = {DEV_ADDR, 1'b0, word};
  assign q_end    = (div == DIV_LAST);
  assign slot_end = q_end && (q == 2'd3);

  function automatic logic [15:0] table_word(input logic [3:0] i);
    case (i)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0C00;
      4'd2:    table_word = 16'h0017;
      4'd3:    table_word = 16'h0217;
      4'd4:    table_word = 16'h0479;
      4'd5:    table_word = 16'h0679;
      4'd6:    table_word = 16'h0812;
      4'd7:    table_word = 16'h0A00;
      4'd8:    table_word = 16'h0E01;
      4'd9:    table_word = 16'h1000;
      default: table_word = 16'h1201;
    endcase
  endfunction

  // Returns {scl, sda_pull_low} for a slot type at quarter qq carrying data bit b.
  function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] qq, input logic b);
    logic mid;
    mid = (qq == 2'd1) || (qq == 2'd2);
    case (st)
      START:   line_drive = {1'b1, qq[1]};
      BIT:     line_drive = {mid, ~b};
      ACK:     line_drive = {mid, 1'b0};
      STOP:    line_drive = {qq != 2'd0, ~qq[1]};
      default: line_drive = 2'b10;
    endcase
  endfunction

`ifdef CODEC_CFG_RETRY_EN
  logic [1:0] retry_cnt;

  assign retry_ok = (retry_cnt != 2'd3);

  // Counts NACKed attempts of the current word; any other GAP exit starts a fresh word.
  always_ff @(posedge clk) begin
    if (reset)
      retry_cnt <= 2'd0;
    else if (state == GAP && slot_end)
      retry_cnt <= (nack_seen && retry_ok) ? retry_cnt + 2'd1 : 2'd0;
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      div              <= '0;
      q                <= 2'd0;
      bit_cnt          <= 3'd0;
      byte_cnt         <= 2'd0;
      idx              <= 4'd0;
      init_run         <= 1'b0;
      nack_seen        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      audio_en         <= 1'b0;
      bus.cfg_wr_ready <= 1'b0;
      bus.i2c_sclk     <= 1'b1;
      bus.i2c_sdat_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start) begin
            state            <= START;
            idx              <= 4'd0;
            word             <= table_word(4'd0);
            init_run         <= 1'b1;
            nack_seen        <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            error            <= 1'b0;
            audio_en         <= 1'b0;
            bus.cfg_wr_ready <= 1'b0;
          end else if (state == READY && bus.cfg_wr_valid && bus.cfg_wr_ready) begin
            state            <= START;
            word             <= bus.cfg_wr_data;
            init_run         <= 1'b0;
            nack_seen        <= 1'b0;
            busy             <= 1'b1;
            bus.cfg_wr_ready <= 1'b0;
          end
        end
        ERR: begin
          state <= IDLE;
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          div <= q_end ? '0 : div + 1'b1;
          if (state == ACK && q == 2'd1 && q_end)
            nack_seen <= nack_seen | bus.i2c_sdat_in;
          if (q_end && q != 2'd3) begin
            q <= q + 2'd1;
            {bus.i2c_sclk, bus.i2c_sdat_oe} <= line_drive(state, q + 2'd1, shreg[23]);
          end else if (slot_end) begin
            q <= 2'd0;
            // Slot boundary: pick the next slot and drive its q0 levels in the same edge.
            case (state)
              START: begin
                state    <= BIT;
                shreg    <= frame;
                bit_cnt  <= 3'd7;
                byte_cnt <= 2'd0;
                {bus.i2c_sclk, bus.i2c_sdat_oe} <= line_drive(BIT, 2'd0, frame[23]);
              end
              BIT: begin
                shreg <= {shreg[22:0], 1'b0};
                if (bit_cnt == 3'd0) begin
                  state <= ACK;
                  {bus.i2c_sclk, bus.i2c_sdat_oe} <= line_drive(ACK, 2'd0, 1'b0);
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  {bus.i2c_sclk, bus.i2c_sdat_oe} <= line_drive(BIT, 2'd0, shreg[22]);
                end
              end
              ACK: begin
                if (nack_seen || byte_cnt == 2'd2) begin
                  state <= STOP;
                  {bus.i2c_sclk, bus.i2c_sdat_oe} <= line_drive(STOP, 2'd0, 1'b0);
                end else begin
                  state    <= BIT;
                  bit_cnt  <= 3'd7;
                  byte_cnt <= byte_cnt + 2'd1;
                  {bus.i2c_sclk, bus.i2c_sdat_oe} <= line_drive(BIT, 2'd0, shreg[23]);
                end
              end
              STOP: begin
                state <= GAP;
                {bus.i2c_sclk, bus.i2c_sdat_oe} <= 2'b10;
              end
              GAP: begin
                {bus.i2c_sclk, bus.i2c_sdat_oe} <= 2'b10;
                if (nack_seen && retry_ok) begin
                  state     <= START;
                  nack_seen <= 1'b0;
                end else if (nack_seen && init_run) begin
                  state <= ERR;
                end else if (nack_seen) begin
                  state            <= READY;
                  error            <= 1'b1;
                  busy             <= 1'b0;
                  bus.cfg_wr_ready <= 1'b1;
                end else if (!init_run || idx == LAST_IDX) begin
                  state            <= READY;
                  busy             <= 1'b0;
                  bus.cfg_wr_ready <= 1'b1;
                  if (init_run) begin
                    done     <= 1'b1;
                    audio_en <= 1'b1;
                  end
                end else begin
                  state     <= START;
                  idx       <= idx + 4'd1;
                  word      <= table_word(idx + 4'd1);
                  nack_seen <= 1'b0;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/codec_config_seq.md
# codec_config_seq

Configuration sequencer for the audio codec (WM8731-class) control port. After `start`, it writes a fixed 11-entry register table over a 2-wire serial bus (I2C-style, write-only), then raises `audio_en` to release the serial audio datapath. Once configured, it accepts single host register writes (volume, mute) through a valid/ready port. It sits beside the audio serial controller at the top level and shares no datapath with it.

## Interface
- `CLK_DIV`, 125: clk cycles per quarter bit; 125 @ 50 MHz gives 100 kHz SCL.
- `DEV_ADDR`, 7'h1A: 7-bit codec device address; the R/W bit is always 0.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse; begins the init table; ignored while `busy`.
- `cfg_wr_valid` in 1: host write request.
- `cfg_wr_data` in 16: {reg_addr[6:0], reg_data[8:0]}.
- `cfg_wr_ready` out 1: host write accepted on `valid && ready`.
- `busy` out 1: a transaction or the table is in progress.
- `done` out 1: init table completed without error.
- `error` out 1: sticky NACK flag.
- `audio_en` out 1: audio datapath enable.
- `i2c_sclk` out 1: serial clock.
- `i2c_sdat_oe` out 1: 1 drives SDA low; 0 releases SDA (pulled high).
- `i2c_sdat_in` in 1: sampled SDA.

## Operation
- Reset values:
  - `i2c_sclk`=1, `i2c_sdat_oe`=0.
  - `busy`, `done`, `error`, `audio_en`, `cfg_wr_ready` = 0.
  - Table index = 0.
- Init table, in order: 0x1E00 (reset), 0x0C00, 0x0017, 0x0217, 0x0479, 0x0679, 0x0812, 0x0A00, 0x0E01 (left-justified, 16-bit, slave), 0x1000, 0x1201 (active).
- On `start`:
  - Clear `done`, `error`, `audio_en`; set `busy`.
  - Write the table entries in index order.
  - After the last entry: `busy`=0, and `done`=`audio_en`=1 if no NACK occurred.
- States: IDLE → START → BIT → ACK → (BIT | STOP) → GAP → (START | READY | IDLE | ERR).
  - After reset the FSM is in IDLE. READY is entered only after a successful init.
  - ERR returns to IDLE with `error`=1.
- Transaction frame: START, three bytes each followed by an ACK slot, STOP, GAP.
  - Byte 0: {DEV_ADDR, 0}. Byte 1: word[15:8]. Byte 2: word[7:0]. All MSB first.
- ACK handling:
  - `i2c_sdat_in`=1 during an ACK slot is a NACK.
  - A NACK abandons the remaining bits, goes to STOP, then GAP, and sets `error`.
  - During init, a NACK ends the table and `audio_en` stays 0.
- READY state and host writes:
  - `cfg_wr_ready`=1 only in READY.
  - On handshake, the word is captured, `ready` drops the next cycle, and `busy`=1 until GAP ends.
  - A host-write NACK sets `error`, returns to READY, and leaves `audio_en`=1.
- `start` in READY re-runs the init table.
- `reset` at any point forces reset values on the next edge, even mid-transaction.

## Timing
- One quarter = `CLK_DIV` cycles. A slot = 4 quarters (q0–q3).
- START slot:
  - q0–q1: SDA released, SCL=1.
  - q2–q3: SDA driven low, SCL=1.
- Data/ACK slot:
  - SDA changes at the first cycle of q0.
  - SCL=0 in q0, 1 in q1–q2, 0 in q3.
  - For ACK slots SDA is released, and `i2c_sdat_in` is sampled on the last cycle of q1.
- STOP slot:
  - q0: SCL=0, SDA low.
  - q1: SCL=1, SDA low.
  - q2–q3: SCL=1, SDA released.
- GAP slot: SCL=1, SDA released.
- Transaction length = 30 slots = 120·`CLK_DIV` cycles, from the START first cycle to the GAP end.
- Full init = 11·120·`CLK_DIV` cycles after the `start` edge.
  - `done`/`audio_en` rise on the cycle after the final GAP.
- Host write: `busy` rises 1 cycle after handshake; START begins in the same cycle.

## Configuration
- `CODEC_CFG_RETRY_EN` defined:
  - A NACKed word is re-sent after its STOP+GAP, up to 3 retries (4 attempts total).
  - `error` is set only after the 4th NACK.
  - The retry counter clears on each new word.
- `CODEC_CFG_RETRY_EN` undefined: the first NACK sets `error` immediately, as described above.

## Test plan
- All-ACK bench model, `CLK_DIV`=4, pulse `start` → 11 frames, bytes 0x34,0x1E,0x00 … 0x34,0x12,0x01. `done`=`audio_en`=1 exactly 5280 cycles after `start`.
- NACK on byte 1 of entry 3 (no macro) → STOP issued, `error`=1, `done`=`audio_en`=0, no further frames, `busy`=0.
- Same NACK with `CODEC_CFG_RETRY_EN`, ACK on 2nd attempt → entry 3 sent twice, `error`=0, `done`=1.
- After init, `cfg_wr_data`=0x0470 with valid held → accepted once, `cfg_wr_ready` low until GAP end, bytes 0x34,0x04,0x70.
- `start` pulse while `busy` → ignored, table continues unaltered.
- `reset` asserted during a bit slot → next cycle `i2c_sclk`=1, `i2c_sdat_oe`=0, all status 0. A later `start` reruns the table from entry 0.
